// File: rtl/vdc_ram_sched.sv
// vdc_ram_sched: slot scheduler for the single 8-bit video RAM port.
// Arbitrates display fetch, refresh, CPU and block engine accesses,
// applies 16K/64K address mapping and returns read data to its owner.
module vdc_ram_sched #(
    parameter int unsigned RAM_ADDR_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     newLine,
    input  logic [3:0]               reg_drr,
    input  logic                     ram64k,
    input  logic                     reg_ram,
    input  logic                     disp_req,
    input  logic [15:0]              disp_addr,
    output logic                     disp_ack,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [15:0]              cpu_addr,
    input  logic [7:0]               cpu_wdata,
    output logic                     cpu_ack,
    input  logic                     blk_req,
    input  logic                     blk_we,
    input  logic [15:0]              blk_addr,
    input  logic [7:0]               blk_wdata,
    output logic                     blk_ack,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic                     ram_we,
    output logic [7:0]               ram_din,
    input  logic [7:0]               ram_dout,
    output logic                     rd_valid,
    output logic [1:0]               rd_src,
    output logic [7:0]               rd_data,
    output logic                     idle
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned QW = 4;
    localparam int unsigned RW = 8;

    typedef enum logic [1:0] {
        SRC_DISP = 2'd0,
        SRC_REF  = 2'd1,
        SRC_CPU  = 2'd2,
        SRC_BLK  = 2'd3
    } src_t;

    typedef enum logic {
        RR_CPU = 1'b0,
        RR_BLK = 1'b1
    } rr_t;

    logic [QW-1:0]            quota;
    logic [QW-1:0]            quota_eff;
    logic [RW-1:0]            ref_cnt;
    rr_t                      rr;
    rr_t                      rr_next;

    logic                     gnt_c;
    src_t                     win_c;
    logic [AW-1:0]            addr_c;
    logic                     we_c;
    logic [DW-1:0]            din_c;
    logic [RAM_ADDR_BITS-1:0] map_c;

    logic                     rd_pend;
    src_t                     rd_src_pend;
    logic                     gnt1;
    logic                     gnt2;

    // Slot winner selection; a newLine in the same cycle reloads the quota first
    always_comb begin
        gnt_c     = 1'b0;
        win_c     = SRC_DISP;
        addr_c    = '0;
        we_c      = 1'b0;
        din_c     = '0;
        rr_next   = rr;
        quota_eff = newLine ? reg_drr : quota;
        if (enable) begin
            if (disp_req) begin
                gnt_c  = 1'b1;
                win_c  = SRC_DISP;
                addr_c = disp_addr;
            end else if (quota_eff != '0) begin
                gnt_c  = 1'b1;
                win_c  = SRC_REF;
                addr_c = AW'(ref_cnt);
            end else if (cpu_req && (!blk_req || rr == RR_CPU)) begin
                gnt_c   = 1'b1;
                win_c   = SRC_CPU;
                addr_c  = cpu_addr;
                we_c    = cpu_we;
                din_c   = cpu_wdata;
                rr_next = RR_BLK;
            end else if (blk_req) begin
                gnt_c   = 1'b1;
                win_c   = SRC_BLK;
                addr_c  = blk_addr;
                we_c    = blk_we;
                din_c   = blk_wdata;
                rr_next = RR_CPU;
            end
        end
    end

    // 64K addressing only when the RAM is fitted and enabled, else a 16K window
    always_comb begin
        map_c = RAM_ADDR_BITS'(addr_c[13:0]);
        if (ram64k && reg_ram) begin
            map_c = RAM_ADDR_BITS'(addr_c);
        end
    end

    // Grant outputs, refresh bookkeeping and read-return pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_ack    <= 1'b0;
            cpu_ack     <= 1'b0;
            blk_ack     <= 1'b0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_din     <= '0;
            rd_valid    <= 1'b0;
            rd_src      <= '0;
            quota       <= '0;
            ref_cnt     <= '0;
            rr          <= RR_CPU;
            rd_pend     <= 1'b0;
            rd_src_pend <= SRC_DISP;
            gnt1        <= 1'b0;
            gnt2        <= 1'b0;
        end else begin
            disp_ack <= gnt_c && (win_c == SRC_DISP);
            cpu_ack  <= gnt_c && (win_c == SRC_CPU);
            blk_ack  <= gnt_c && (win_c == SRC_BLK);
            ram_we   <= gnt_c && we_c;
            if (gnt_c) begin
                ram_addr <= map_c;
                ram_din  <= din_c;
            end
            rd_pend     <= gnt_c && !we_c;
            rd_src_pend <= win_c;
            rd_valid    <= rd_pend;
            if (rd_pend) begin
                rd_src <= rd_src_pend;
            end
            gnt1 <= gnt_c;
            gnt2 <= gnt1;
            rr   <= rr_next;
            if (gnt_c && (win_c == SRC_REF)) begin
                ref_cnt <= ref_cnt + RW'(1);
            end
            if (newLine) begin
                quota <= reg_drr;
            end else if (gnt_c && (win_c == SRC_REF) && (quota != '0)) begin
                quota <= quota - QW'(1);
            end
        end
    end

    assign rd_data = ram_dout;
    assign idle    = !cpu_req && !blk_req && !gnt1 && !gnt2;

endmodule
